// File: rtl/ai_accel_pkg.sv
// Shared types and constants for the AI core units: data-type codes,
// activation selectors, FP32 zero encodings and the activation FSM states.
package ai_accel_pkg;

  localparam logic [2:0] DT_INT32 = 3'b010;
  localparam logic [2:0] DT_FP32  = 3'b101;

  typedef enum logic [1:0] {
    ACT_RELU  = 2'd0,
    ACT_CLIP  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_PASS  = 2'd3
  } act_e;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_APPLY,
    ST_STORE,
    ST_DONE
  } state_e;

  // Any code other than the FP32 code is handled as INT32.
  function automatic logic is_fp32(input logic [2:0] dt);
    return dt == DT_FP32;
  endfunction

endpackage

// File: rtl/ai_act_alu.sv
// Purely combinational element-wise activation function for INT32 and FP32
// elements; kept stateless so a streaming datapath can reuse it.
module ai_act_alu
  import ai_accel_pkg::*;
(
  input  logic [31:0] x,
  input  logic [1:0]  act_type,
  input  logic [2:0]  data_type,
  input  logic [31:0] act_param,
  output logic [31:0] y
);

  logic        is_fp;
  logic [4:0]  shamt;
  logic [7:0]  exp_x;
  logic [7:0]  exp_sh;
  logic [31:0] relu_y;

  assign is_fp  = is_fp32(data_type);
  assign shamt  = act_param[4:0];
  assign exp_x  = x[30:23];
  assign exp_sh = {3'b000, shamt};

  // Both formats keep the sign in bit 31 and encode zero as all zeros, so one
  // ReLU serves both; for FP32 this also maps -0, -inf and negative NaNs to +0.
  assign relu_y = x[31] ? FP_POS_ZERO : x;

  always_comb begin
    y = x;
    case (act_e'(act_type))
      ACT_RELU: y = relu_y;
      ACT_CLIP: begin
        // Non-negative FP32 values order the same as their unsigned bit patterns.
        if (is_fp) y = (relu_y > act_param) ? act_param : relu_y;
        else       y = ($signed(relu_y) > $signed(act_param)) ? act_param : relu_y;
      end
      ACT_LEAKY: begin
        if (x[31]) begin
          if (is_fp) begin
            if (exp_x == 8'hFF)       y = x;
            else if (exp_x <= exp_sh) y = FP_NEG_ZERO;
            else                      y = {1'b1, exp_x - exp_sh, x[22:0]};
          end else begin
            y = $signed(x) >>> shamt;
          end
        end
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/ai_activation_unit.sv
// Memory-to-memory activation stage: loads each element, applies the selected
// activation and stores it to the output buffer for the pooling unit.
module ai_activation_unit
  import ai_accel_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [1:0]      act_type,
  input  logic [2:0]      data_type,
  input  logic [XLEN-1:0] input_addr,
  input  logic [XLEN-1:0] output_addr,
  input  logic [31:0]     num_elements,
  input  logic [31:0]     act_param,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  output logic            mem_req,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            busy,
  output logic [XLEN-1:0] result,
  output logic            valid
);

  state_e                 state_q, state_d;
  logic [1:0]             act_q;
  logic [2:0]             dt_q;
  logic [XLEN-1:0]        in_base_q;
  logic [XLEN-1:0]        out_base_q;
  logic [31:0]            count_q;
  logic [31:0]            param_q;
  logic [31:0]            idx_q;
  logic [DATA_WIDTH-1:0]  x_q;
  logic [DATA_WIDTH-1:0]  y_q;
  logic [31:0]            alu_y;
  logic [XLEN-1:0]        idx_off;
  logic                   count_zero;
  logic                   last_elem;
  logic [XLEN-DATA_WIDTH-1:0] unused_rdata_hi;

  assign unused_rdata_hi = mem_rdata[XLEN-1:DATA_WIDTH];
  assign idx_off    = XLEN'(idx_q) << 2;
  assign count_zero = (count_q == 32'd0);
  assign last_elem  = ((idx_q + 32'd1) == count_q);

  ai_act_alu u_alu (
    .x         (x_q),
    .act_type  (act_q),
    .data_type (dt_q),
    .act_param (param_q),
    .y         (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      act_q      <= '0;
      dt_q       <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      count_q    <= '0;
      param_q    <= '0;
      idx_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            act_q      <= act_type;
            dt_q       <= data_type;
            in_base_q  <= input_addr;
            out_base_q <= output_addr;
            count_q    <= num_elements;
            param_q    <= act_param;
            idx_q      <= '0;
          end
        end
        ST_LOAD:  if (mem_ready && !count_zero) x_q <= mem_rdata[DATA_WIDTH-1:0];
        ST_APPLY: y_q <= alu_y;
        ST_STORE: if (mem_ready) idx_q <= idx_q + 32'd1;
        default:  ;
      endcase
    end
  end

  // An empty job still passes through LOAD (with no request) so that the
  // zero-count test is made on the latched count rather than the live input.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = 8'h00;
    valid     = 1'b0;
    result    = '0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_LOAD;
      ST_LOAD: begin
        if (count_zero) begin
          state_d = ST_DONE;
        end else begin
          mem_req  = 1'b1;
          mem_addr = in_base_q + idx_off;
          if (mem_ready) state_d = ST_APPLY;
        end
      end
      ST_APPLY: state_d = ST_STORE;
      ST_STORE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = out_base_q + idx_off;
        mem_wdata = {{(XLEN-DATA_WIDTH){1'b0}}, y_q};
        mem_wmask = 8'h0F;
        if (mem_ready) state_d = last_elem ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        valid   = 1'b1;
        result  = out_base_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ai_activation_unit.sv
// Directed self-checking bench for ai_activation_unit with a word-addressed
// memory model that can insert random request stalls.
module tb_ai_activation_unit;
  import ai_accel_pkg::*;

  localparam int          XLEN     = 64;
  localparam logic [63:0] IN_BASE  = 64'h100;
  localparam logic [63:0] OUT_BASE = 64'h200;
  localparam int          IN_W     = 64;
  localparam int          OUT_W    = 128;
  localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b0;
  logic [1:0]      act_type = '0;
  logic [2:0]      data_type = '0;
  logic [XLEN-1:0] input_addr = '0;
  logic [XLEN-1:0] output_addr = '0;
  logic [31:0]     num_elements = '0;
  logic [31:0]     act_param = '0;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [7:0]      mem_wmask;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;
  logic            busy;
  logic [XLEN-1:0] result;
  logic            valid;

  logic [31:0] mem_model [0:255];
  logic [31:0] in_v  [4];
  logic [31:0] exp_v [4];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          stall_en = 1'b0;
  int          wait_left = 0;
  bit          new_req = 1'b1;
  int          req_count = 0;
  logic [63:0] hold_addr;
  logic [63:0] hold_wdata;
  logic        hold_we;

  ai_activation_unit #(.XLEN(XLEN), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .act_type     (act_type),
    .data_type    (data_type),
    .input_addr   (input_addr),
    .output_addr  (output_addr),
    .num_elements (num_elements),
    .act_param    (act_param),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .busy         (busy),
    .result       (result),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  // Memory responder: decides mem_ready on the falling edge and checks that a
  // stalled request holds its address, direction and data.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (!mem_req || rst) begin
        new_req = 1'b1;
      end else begin
        if (new_req) begin
          hold_addr  = mem_addr;
          hold_we    = mem_we;
          hold_wdata = mem_wdata;
          new_req    = 1'b0;
          req_count++;
          wait_left  = stall_en ? int'($urandom_range(0, 5)) : 0;
        end else begin
          checkOutput("stall_addr", mem_addr, hold_addr);
          checkOutput("stall_we", {63'h0, mem_we}, {63'h0, hold_we});
          checkOutput("stall_wdata", mem_wdata, hold_wdata);
        end
        if (wait_left == 0) begin
          mem_ready = 1'b1;
          checkOutput("wmask", {56'h0, mem_wmask}, mem_we ? 64'h0F : 64'h00);
          if (mem_we) begin
            checkOutput("wdata_hi", {32'h0, mem_wdata[63:32]}, 64'h0);
            mem_model[mem_addr[9:2]] = mem_wdata[31:0];
          end else begin
            mem_rdata = {32'h0, mem_model[mem_addr[9:2]]};
          end
          new_req = 1'b1;
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Starts one job, scrambles the inputs after the start cycle and waits for valid.
  task automatic applyStimulus(input logic [1:0] act, input logic [2:0] dt, input logic [31:0] param,
                               input int n, input bit poke, output int cycles);
    bit seen = 1'b0;
    @(negedge clk);
    act_type     = act;
    data_type    = dt;
    act_param    = param;
    num_elements = 32'(n);
    input_addr   = IN_BASE;
    output_addr  = OUT_BASE;
    enable       = 1'b1;
    cycles       = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      enable = 1'b0;
      if (k == 1) begin
        checkOutput("busy", {63'h0, busy}, 64'h1);
        act_type     = ~act;
        data_type    = ~dt;
        act_param    = ~param;
        num_elements = 32'(n + 5);
        input_addr   = 64'hF00;
        output_addr  = 64'hF00;
      end
      if (poke && k == 4) begin
        enable       = 1'b1;
        num_elements = 32'd1;
        output_addr  = 64'h300;
      end
      if (valid) begin
        seen   = 1'b1;
        cycles = k;
        checkOutput("result", result, OUT_BASE);
        break;
      end
    end
    checkOutput("valid_seen", {63'h0, seen}, 64'h1);
    @(negedge clk);
    checkOutput("valid_once", {63'h0, valid}, 64'h0);
  endtask

  task automatic runJob(input string tag, input logic [1:0] act, input logic [2:0] dt,
                        input logic [31:0] param, input int n, input bit poke, input int exp_lat);
    int cycles;
    for (int i = 0; i < 4; i++) begin
      mem_model[IN_W + i]  = in_v[i];
      mem_model[OUT_W + i] = SENTINEL;
    end
    mem_model[OUT_W + 4] = SENTINEL;
    applyStimulus(act, dt, param, n, poke, cycles);
    if (exp_lat >= 0) checkOutput({tag, "_latency"}, 64'(cycles), 64'(exp_lat));
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_y%0d", tag, i), {32'h0, mem_model[OUT_W + i]}, {32'h0, exp_v[i]});
    checkOutput({tag, "_tail"}, {32'h0, mem_model[OUT_W + n]}, {32'h0, SENTINEL});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  rc0;
    int  vseen;
    bit  found;
    for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {63'h0, busy}, 64'h0);
    checkOutput("rst_req", {62'h0, mem_req, mem_we}, 64'h0);
    checkOutput("rst_valid", {63'h0, valid}, 64'h0);
    checkOutput("rst_result", result, 64'h0);
    checkOutput("rst_addr", mem_addr, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    in_v  = '{32'd5, 32'hFFFF_FFFD, 32'd0, 32'h8000_0000};
    exp_v = '{32'd5, 32'd0, 32'd0, 32'd0};
    runJob("int_relu", 2'd0, DT_INT32, 32'd0, 4, 1'b0, 13);

    in_v  = '{32'hFFFF_FFFF, 32'd3, 32'd6, 32'd100};
    exp_v = '{32'd0, 32'd3, 32'd6, 32'd6};
    runJob("int_clip_poke", 2'd1, DT_INT32, 32'd6, 4, 1'b1, 13);

    in_v  = '{32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd7, 32'd0};
    exp_v = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd7, 32'd0};
    runJob("int_leaky", 2'd2, 3'b000, 32'd2, 3, 1'b0, 10);

    in_v  = '{32'hBF80_0000, 32'h3F80_0000, 32'h8000_0000, 32'd0};
    exp_v = '{32'h0, 32'h3F80_0000, 32'h0, 32'd0};
    runJob("fp_relu", 2'd0, DT_FP32, 32'd0, 3, 1'b0, 10);

    in_v  = '{32'hC000_0000, 32'hFF80_0000, 32'h8080_0000, 32'h4000_0000};
    exp_v = '{32'hBF80_0000, 32'hFF80_0000, 32'h8000_0000, 32'h4000_0000};
    runJob("fp_leaky", 2'd2, DT_FP32, 32'd1, 4, 1'b0, 13);

    in_v  = '{32'hC000_0000, 32'h4000_0000, 32'h4100_0000, 32'h7F80_0000};
    exp_v = '{32'h0, 32'h4000_0000, 32'h40C0_0000, 32'h40C0_0000};
    runJob("fp_clip", 2'd1, DT_FP32, 32'h40C0_0000, 4, 1'b0, 13);

    in_v  = '{32'h1234_5678, 32'h8000_0001, 32'd0, 32'd0};
    exp_v = '{32'h1234_5678, 32'h8000_0001, 32'd0, 32'd0};
    runJob("pass", 2'd3, DT_FP32, 32'd0, 2, 1'b0, 7);

    rc0 = req_count;
    runJob("empty", 2'd0, DT_INT32, 32'd0, 0, 1'b0, 2);
    checkOutput("empty_noreq", 64'(req_count), 64'(rc0));

    stall_en = 1'b1;
    in_v  = '{32'd5, 32'hFFFF_FFFD, 32'd0, 32'h8000_0000};
    exp_v = '{32'd5, 32'd0, 32'd0, 32'd0};
    runJob("stall_relu", 2'd0, DT_INT32, 32'd0, 4, 1'b0, -1);
    in_v  = '{32'hC000_0000, 32'hFF80_0000, 32'h8080_0000, 32'h4000_0000};
    exp_v = '{32'hBF80_0000, 32'hFF80_0000, 32'h8000_0000, 32'h4000_0000};
    runJob("stall_fp_leaky", 2'd2, DT_FP32, 32'd1, 4, 1'b0, -1);
    stall_en = 1'b0;

    // Abort a job while it is storing element 2 of 4.
    in_v = '{32'd5, 32'hFFFF_FFFD, 32'd0, 32'h8000_0000};
    for (int i = 0; i < 4; i++) mem_model[IN_W + i] = in_v[i];
    @(negedge clk);
    act_type = 2'd0; data_type = DT_INT32; act_param = 32'd0; num_elements = 32'd4;
    input_addr = IN_BASE; output_addr = OUT_BASE; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    found  = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (mem_req && mem_we && mem_addr == OUT_BASE + 64'h8) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("abort_found", {63'h0, found}, 64'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_req", {63'h0, mem_req}, 64'h0);
    checkOutput("abort_busy", {63'h0, busy}, 64'h0);
    vseen = 0;
    repeat (12) begin
      if (valid) vseen++;
      @(negedge clk);
    end
    checkOutput("abort_novalid", 64'(vseen), 64'h0);

    exp_v = '{32'd5, 32'd0, 32'd0, 32'd0};
    runJob("after_abort", 2'd0, DT_INT32, 32'd0, 4, 1'b0, 13);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
